// File: rtl/aes_key_expand.sv
// AES-128/192/256 key-expansion engine: one schedule word per cycle into a word memory,
// with round keys read combinationally. Define AES_KEY_192_EN to enable AES-192 (keylen 01).
module aes_key_expand #(
  parameter int MAX_WORDS   = 60,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [1:0]   keylen,
  input  logic [255:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [3:0]   nr,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  typedef enum logic [1:0] {IDLE, LOAD, GEN} state_t;

  state_t       state;
  logic [5:0]   word_ctr;
  logic [7:0]   rcon_reg;
  logic [2:0]   kcnt;
  logic [3:0]   nk_reg;
  logic [3:0]   nr_reg;
  logic [255:0] key_reg;
  logic [31:0]  w [MAX_WORDS];

  logic [3:0]   nk_sel;
  logic [3:0]   nr_sel;
  logic [5:0]   nw_last;
  logic [31:0]  prev_word;
  logic [31:0]  base_word;
  logic [31:0]  temp;
  logic [7:0]   rcon_next;
  logic [2:0]   kcnt_next;
  logic [5:0]   rbase;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    case (keylen)
`ifdef AES_KEY_192_EN
      2'b01: begin nk_sel = 4'd6; nr_sel = 4'd12; end
`endif
      2'b10: begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: ;
    endcase
  end

  assign nw_last   = {nr_reg, 2'b00} + 6'd3;
  assign prev_word = w[word_ctr - 6'd1];
  assign base_word = w[word_ctr - {2'b00, nk_reg}];
  assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

  // The S-box result is rotated after substitution, which equals SubWord(RotWord(x)).
  always_comb begin
    temp = prev_word;
    if (kcnt == 3'd0)
      temp = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_reg, 24'h0};
    else if (nk_reg == 4'd8 && kcnt == 3'd4)
      temp = new_sboxw;
  end

`ifdef AES_KEY_192_EN
  // nk_reg[2:0] - 1 wraps to 7 for Nk = 8, so one compare covers all three key sizes.
  assign kcnt_next = (kcnt == nk_reg[2:0] - 3'd1) ? 3'd0 : kcnt + 3'd1;
`else
  assign kcnt_next = nk_reg[3] ? kcnt + 3'd1 : {1'b0, kcnt[1:0] + 2'd1};
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b0;
      nr_reg   <= 4'd0;
      nk_reg   <= 4'd4;
      word_ctr <= 6'd0;
      rcon_reg <= 8'h01;
      kcnt     <= 3'd0;
      key_reg  <= '0;
    end else if (init) begin
      nk_reg  <= nk_sel;
      nr_reg  <= nr_sel;
      key_reg <= key;
      ready   <= 1'b0;
      state   <= LOAD;
    end else begin
      case (state)
        LOAD: begin
          word_ctr <= {2'b00, nk_reg};
          rcon_reg <= 8'h01;
          kcnt     <= 3'd0;
          state    <= GEN;
        end
        GEN: begin
          word_ctr <= word_ctr + 6'd1;
          kcnt     <= kcnt_next;
          if (kcnt == 3'd0) rcon_reg <= rcon_next;
          if (word_ctr == nw_last) begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the word memory is cleared on reset only when RESET_CLEAR is set; otherwise it keeps
  // stale words and only ready qualifies them.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RESET_CLEAR)
        for (int i = 0; i < MAX_WORDS; i++) w[i] <= '0;
    end else if (!init) begin
      if (state == LOAD) begin
        for (int i = 0; i < 8; i++)
          if (4'(i) < nk_reg) w[i] <= key_reg[255 - 32*i -: 32];
      end else if (state == GEN) begin
        w[word_ctr] <= base_word ^ temp;
      end
    end
  end

  assign rbase = {round, 2'b00};

  always_comb begin
    round_key = '0;
    if (round <= nr_reg)
      round_key = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
  end

  assign nr    = nr_reg;
  assign sboxw = (state == GEN) ? prev_word : 32'h0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, random keys against a
// FIPS-style reference schedule, restart, reset mid-run and reset/init collision.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [1:0]   keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [3:0]   nr;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] mw [60];
  int          m_nk;
  int          m_nr;

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .keylen    (keylen),
    .key       (key),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .nr        (nr),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  always #5 clk = ~clk;

  // Shared S-box stand-in, combinational like the round datapath's.
  assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]],
                      sbox_t[sboxw[15:8]],  sbox_t[sboxw[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < j; i++) r = xt(r);
    return r;
  endfunction

  // Textbook key schedule: w[i] = w[i-Nk] ^ f(w[i-1]).
  task automatic model(input logic [1:0] kl, input logic [255:0] k);
    int nw;
    logic [31:0] t;
    case (kl)
      2'b10: begin m_nk = 8; m_nr = 14; end
`ifdef AES_KEY_192_EN
      2'b01: begin m_nk = 6; m_nr = 12; end
`endif
      default: begin m_nk = 4; m_nr = 10; end
    endcase
    nw = 4 * (m_nr + 1);
    for (int i = 0; i < 60; i++) mw[i] = 32'h0;
    for (int i = 0; i < m_nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = m_nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % m_nk == 0)
        t = subword({t[23:0], t[31:24]}) ^ {rcon_of(i / m_nk), 24'h0};
      else if (m_nk > 6 && i % m_nk == 4)
        t = subword(t);
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  task automatic model_cleared();
    for (int i = 0; i < 60; i++) mw[i] = 32'h0;
    m_nr = 0;
    m_nk = 4;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_round(input string tag, input int r, input logic [127:0] exp);
    @(negedge clk);
    round = 4'(r);
    #1;
    check(tag, round_key, exp);
  endtask

  task automatic check_rounds(input string tag);
    for (int r = 0; r < 16; r++) begin
      logic [127:0] exp = '0;
      if (r <= m_nr) exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      check_round($sformatf("%s round %0d", tag, r), r, exp);
    end
  endtask

  task automatic start(input logic [1:0] kl, input logic [255:0] k, input string tag);
    @(negedge clk);
    keylen = kl;
    key    = k;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    check({tag, " ready low after init"}, 128'(ready), 128'(0));
  endtask

  // Counts edges from the init edge until ready; a blown budget shows up as a latency mismatch.
  task automatic wait_ready(input string tag, input int first_cyc, input int exp_lat);
    int cyc = first_cyc;
    while (!ready && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
  endtask

  task automatic run(input logic [1:0] kl, input logic [255:0] k, input string tag);
    model(kl, k);
    start(kl, k, tag);
    @(posedge clk);
    #1;
    check({tag, " first sboxw"}, 128'(sboxw), 128'(mw[m_nk-1]));
    wait_ready(tag, 1, 1 + 4 * (m_nr + 1) - m_nk);
    check({tag, " nr"}, 128'(nr), 128'(m_nr));
    check_rounds(tag);
    check({tag, " ready held"}, 128'(ready), 128'(1));
    check({tag, " idle sboxw"}, 128'(sboxw), 128'(0));
  endtask

  initial begin
    reset  = 1'b1;
    init   = 1'b0;
    keylen = 2'b00;
    key    = '0;
    round  = 4'd0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset ready", 128'(ready), 128'(0));
    check("reset nr", 128'(nr), 128'(0));
    check("reset sboxw", 128'(sboxw), 128'(0));
    check("reset round_key", round_key, 128'(0));

    // FIPS-197 vectors.
    run(2'b00, KEY_A1, "A1");
    check_round("A1 const round 10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_round("A1 const round 0", 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run(2'b01, KEY_A2, "A2");
`ifdef AES_KEY_192_EN
    check("A2 const nr", 128'(nr), 128'(12));
    check_round("A2 const round 12", 12, 128'he98ba06f448c773c8ecc720401002202);
`else
    check("A2 const nr", 128'(nr), 128'(10));
`endif

    run(2'b10, KEY_A3, "A3");
    check_round("A3 const round 14", 14, 128'hfe4890d1e6188d0b046df344706c631e);
    check_round("A3 const round 15", 15, 128'h0);

    run(2'b11, KEY_A1, "keylen11");
    check_round("keylen11 const round 10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys for every keylen encoding.
    for (int kl = 0; kl < 4; kl++) begin
      for (int n = 0; n < 2; n++) begin
        logic [255:0] rk;
        for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
        run(2'(kl), rk, $sformatf("rand kl%0d #%0d", kl, n));
      end
    end

    // Restart: AES-256 aborted 20 cycles in by an AES-128 init.
    start(2'b10, KEY_A3, "restart first");
    repeat (19) @(posedge clk);
    #1;
    check("restart ready before second init", 128'(ready), 128'(0));
    model(2'b00, KEY_A1);
    start(2'b00, KEY_A1, "restart second");
    wait_ready("restart", 0, 41);
    check("restart nr", 128'(nr), 128'(10));
    check_rounds("restart");

    // Reset 10 cycles into generation.
    start(2'b10, KEY_A3, "midreset");
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset ready", 128'(ready), 128'(0));
    check("midreset nr", 128'(nr), 128'(0));
    check("midreset sboxw", 128'(sboxw), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    model_cleared();
    check_rounds("midreset");

    // init coinciding with reset: reset wins and the block stays idle.
    @(negedge clk);
    reset  = 1'b1;
    init   = 1'b1;
    keylen = 2'b00;
    key    = KEY_A1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    init  = 1'b0;
    check("collide ready", 128'(ready), 128'(0));
    check("collide nr", 128'(nr), 128'(0));
    repeat (5) @(posedge clk);
    #1;
    check("collide later sboxw", 128'(sboxw), 128'(0));
    check("collide later nr", 128'(nr), 128'(0));
    check("collide later ready", 128'(ready), 128'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
